ucore_mem_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one memory/peripheral port between NREQ generated ucore FSM program instances. It accepts one request at a time, issues it on the shared port, waits for the response, and returns it to the owning requester. A timeout is applied to every response wait. The block sits between the ucore instances and the system bus adapter.

---
 rtl/ucore_mem_arbiter_if.sv | 46 ++++
 rtl/ucore_mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ucore_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ucore_mem_arbiter_if.sv
// Bundle of requester-side and shared-memory-side signals for ucore_mem_arbiter.
// The arbiter connects through the slave modport. The environment (the ucore
// instances plus the bus adapter) connects through the master modport.
interface ucore_mem_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // requester side
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic                   rsp_err;
  logic [DATA_W-1:0]      rsp_rdata;

  // shared memory port
  logic                   mem_req;
  logic                   mem_write;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_gnt;
  logic                   mem_rsp_valid;
  logic [DATA_W-1:0]      mem_rdata;

  // status
  logic                   spurious;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem_gnt, mem_rsp_valid, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output mem_req, mem_write, mem_addr, mem_wdata,
    output spurious
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output mem_gnt, mem_rsp_valid, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  mem_req, mem_write, mem_addr, mem_wdata,
    input  spurious
  );
endinterface

// File: rtl/ucore_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port between NREQ ucore
// program instances. It handles one transaction at a time in the sequence
// IDLE -> ISSUE -> (WAIT) -> RESP. Every response wait is bounded by a timeout.
module ucore_mem_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             resetn,
  ucore_mem_arbiter_if.slave bus
);

  localparam int unsigned SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    rr_last_q, rr_last_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                spurious_q, spurious_d;

  logic                pick_found;
  logic [SEL_W-1:0]    pick_idx;

  logic [NREQ-1:0]     req_ready_o;
  logic [NREQ-1:0]     rsp_valid_o;
  logic                rsp_err_o;
  logic [DATA_W-1:0]   rsp_rdata_o;
  logic                mem_req_o;
  logic                mem_write_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;

  // Round-robin search: first pending requester after rr_last, wrapping.
  always_comb begin
    int unsigned cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(rr_last_q) + k) % NREQ;
      if (!pick_found && bus.req_valid[SEL_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = SEL_W'(cand);
      end
    end
  end

  // Next-state, datapath capture and output decode for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_last_d   = rr_last_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    spurious_d  = spurious_q;

    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = '0;
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.mem_rsp_valid) begin
          spurious_d = 1'b1;
        end
        // Gated with resetn so the combinational ready also drops during reset.
        if (pick_found && resetn) begin
          req_ready_o[pick_idx] = 1'b1;
          sel_d   = pick_idx;
          write_d = bus.req_write[pick_idx];
          addr_d  = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d = bus.req_wdata[pick_idx*DATA_W +: DATA_W];
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        mem_req_o   = 1'b1;
        mem_write_o = write_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (bus.mem_gnt && bus.mem_rsp_valid) begin
          rdata_d = bus.mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (bus.mem_gnt) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else if (bus.mem_rsp_valid) begin
          spurious_d = 1'b1;
        end
      end

      WAIT: begin
        if (bus.mem_rsp_valid) begin
          rdata_d = bus.mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      RESP: begin
        rsp_valid_o[sel_q] = 1'b1;
        rsp_err_o          = err_q;
        rsp_rdata_o        = rdata_q;
        rr_last_d          = sel_q;
        state_d            = IDLE;
        if (bus.mem_rsp_valid) begin
          spurious_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rr_last_q  <= SEL_W'(NREQ - 1);
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_last_q  <= rr_last_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      spurious_q <= spurious_d;
    end
  end

  assign bus.req_ready = req_ready_o;
  assign bus.rsp_valid = rsp_valid_o;
  assign bus.rsp_err   = rsp_err_o;
  assign bus.rsp_rdata = rsp_rdata_o;
  assign bus.mem_req   = mem_req_o;
  assign bus.mem_write = mem_write_o;
  assign bus.mem_addr  = mem_addr_o;
  assign bus.mem_wdata = mem_wdata_o;
  assign bus.spurious  = spurious_q;

endmodule

// File: tb/tb_ucore_mem_arbiter.sv
// Directed bench for ucore_mem_arbiter with a response scoreboard.
module tb_ucore_mem_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned TO   = 4;
  localparam logic [31:0] KEY  = 32'hA5A5_0000;

  typedef struct {
    int unsigned   idx;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic               gnt_drv;
  logic               rsp_drv;
  logic               auto_mem;
  logic [DW-1:0]      rdata_drv;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_rsp = 0;

  ucore_mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ucore_mem_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  // In auto mode the memory grants and responds in the same cycle as mem_req.
  assign bus.req_valid     = req_valid;
  assign bus.req_write     = req_write;
  assign bus.req_addr      = req_addr;
  assign bus.req_wdata     = req_wdata;
  assign bus.mem_gnt       = auto_mem ? bus.mem_req : gnt_drv;
  assign bus.mem_rsp_valid = auto_mem ? bus.mem_req : rsp_drv;
  assign bus.mem_rdata     = auto_mem ? (bus.mem_addr ^ KEY) : rdata_drv;

  function automatic logic [NREQ-1:0] onehot(input int unsigned i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]         = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Advance one clock and pop/compare any response strobe against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.rsp_valid !== '0) begin
      n_rsp++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_rsp_valid", 64'(bus.rsp_valid), 64'(onehot(e.idx)));
        chk("sb_rsp_err",   64'(bus.rsp_err),   64'(e.err));
        chk("sb_rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
      end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    gnt_drv   = 1'b0;
    rsp_drv   = 1'b0;
    auto_mem  = 1'b0;
    rdata_drv = '0;

    // Reset state, with requests pending to show ready is held low.
    repeat (2) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_mem_req",   64'(bus.mem_req),   64'd0);
    chk("rst_mem_write", 64'(bus.mem_write), 64'd0);
    chk("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_spurious",  64'(bus.spurious),  64'd0);
    req_valid = '0;
    resetn    = 1'b1;
    tick();

    // Fairness: all four pending, memory answers at once -> 0,1,2,3,0.
    auto_mem = 1'b1;
    for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'h200 + 4 * i, '0);
    req_valid = '1;
    for (int unsigned t = 0; t < 5; t++) begin
      int unsigned ex;
      ex = t % NREQ;
      #1;
      chk("rr_ready", 64'(bus.req_ready), 64'(onehot(ex)));
      sb.push_back('{ex, 1'b0, (32'h200 + 4 * ex) ^ KEY});
      tick();
      chk("rr_mem_req",  64'(bus.mem_req),  64'd1);
      chk("rr_mem_addr", 64'(bus.mem_addr), 64'(32'h200 + 4 * ex));
      if (t == 4) req_valid = '0;
      tick();
      chk("rr_rsp_valid", 64'(bus.rsp_valid), 64'(onehot(ex)));
      tick();
    end
    auto_mem = 1'b0;
    chk("rr_no_spurious", 64'(bus.spurious), 64'd0);

    // Single read from requester 0, gnt one cycle late, response 3 cycles after gnt.
    set_req(0, 1'b0, 32'h100, '0);
    req_valid = 4'b0001;
    #1;
    chk("rd_ready", 64'(bus.req_ready), 64'b0001);
    sb.push_back('{0, 1'b0, 32'hDEAD_BEEF});
    tick();
    req_valid = '0;
    #1;
    chk("rd_mem_req",   64'(bus.mem_req),   64'd1);
    chk("rd_mem_addr",  64'(bus.mem_addr),  64'h100);
    chk("rd_mem_write", 64'(bus.mem_write), 64'd0);
    chk("rd_ready_off", 64'(bus.req_ready), 64'd0);
    tick();
    gnt_drv = 1'b1;
    #1;
    chk("rd_mem_req2", 64'(bus.mem_req), 64'd1);
    tick();
    gnt_drv = 1'b0;
    #1;
    chk("rd_wait_req", 64'(bus.mem_req), 64'd0);
    tick();
    tick();
    rsp_drv   = 1'b1;
    rdata_drv = 32'hDEAD_BEEF;
    tick();
    rsp_drv   = 1'b0;
    rdata_drv = '0;
    chk("rd_rsp_valid", 64'(bus.rsp_valid), 64'b0001);
    chk("rd_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEAD_BEEF);
    tick();
    chk("rd_rsp_once", 64'(bus.rsp_valid), 64'd0);

    // Backpressure: write from requester 1, no grant for 10 cycles.
    set_req(1, 1'b1, 32'h340, 32'h1234_5678);
    req_valid = 4'b0010;
    #1;
    chk("bp_ready", 64'(bus.req_ready), 64'b0010);
    sb.push_back('{1, 1'b0, 32'hCAFE_0001});
    tick();
    req_valid = 4'b1101;
    for (int unsigned c = 0; c < 10; c++) begin
      #1;
      chk("bp_mem_req",   64'(bus.mem_req),   64'd1);
      chk("bp_mem_write", 64'(bus.mem_write), 64'd1);
      chk("bp_mem_addr",  64'(bus.mem_addr),  64'h340);
      chk("bp_mem_wdata", 64'(bus.mem_wdata), 64'h1234_5678);
      chk("bp_others",    64'(bus.req_ready), 64'd0);
      chk("bp_no_rsp",    64'(bus.rsp_valid), 64'd0);
      tick();
    end
    req_valid = '0;
    gnt_drv   = 1'b1;
    rsp_drv   = 1'b1;
    rdata_drv = 32'hCAFE_0001;
    tick();
    gnt_drv   = 1'b0;
    rsp_drv   = 1'b0;
    rdata_drv = '0;
    chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'b0010);
    tick();

    // Timeout: read from requester 3, granted, never answered.
    set_req(3, 1'b0, 32'h7F0, '0);
    req_valid = 4'b1000;
    #1;
    chk("to_ready", 64'(bus.req_ready), 64'b1000);
    sb.push_back('{3, 1'b1, 32'h0});
    tick();
    req_valid = '0;
    gnt_drv   = 1'b1;
    tick();
    gnt_drv   = 1'b0;
    rdata_drv = 32'hFFFF_FFFF;
    chk("to_wait1", 64'(bus.rsp_valid), 64'd0);
    for (int unsigned c = 0; c < TO - 1; c++) begin
      tick();
      chk("to_wait_n", 64'(bus.rsp_valid), 64'd0);
    end
    tick();
    chk("to_rsp_valid", 64'(bus.rsp_valid), 64'b1000);
    chk("to_rsp_err",   64'(bus.rsp_err),   64'd1);
    chk("to_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("to_not_spur",  64'(bus.spurious),  64'd0);
    rdata_drv = '0;
    tick();
    rsp_drv = 1'b1;
    tick();
    rsp_drv = 1'b0;
    chk("to_late_spur", 64'(bus.spurious), 64'd1);

    // Same-cycle gnt and response on a write from requester 2.
    set_req(2, 1'b1, 32'h400, 32'h55);
    req_valid = 4'b0100;
    #1;
    chk("wr_ready", 64'(bus.req_ready), 64'b0100);
    sb.push_back('{2, 1'b0, 32'h0BAD_F00D});
    tick();
    req_valid = '0;
    gnt_drv   = 1'b1;
    rsp_drv   = 1'b1;
    rdata_drv = 32'h0BAD_F00D;
    #1;
    chk("wr_mem_write", 64'(bus.mem_write), 64'd1);
    chk("wr_mem_wdata", 64'(bus.mem_wdata), 64'h55);
    tick();
    gnt_drv   = 1'b0;
    rsp_drv   = 1'b0;
    rdata_drv = '0;
    chk("wr_rsp_valid", 64'(bus.rsp_valid), 64'b0100);
    chk("wr_rsp_err",   64'(bus.rsp_err),   64'd0);
    tick();

    // Reset mid-WAIT with rr_last=2; afterwards requester 0 wins first.
    set_req(0, 1'b0, 32'h500, '0);
    req_valid = 4'b0001;
    #1;
    chk("mr_ready", 64'(bus.req_ready), 64'b0001);
    tick();
    req_valid = '0;
    gnt_drv   = 1'b1;
    tick();
    gnt_drv = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    chk("mr_mem_req",   64'(bus.mem_req),   64'd0);
    chk("mr_mem_addr",  64'(bus.mem_addr),  64'd0);
    chk("mr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mr_rsp_err",   64'(bus.rsp_err),   64'd0);
    chk("mr_spurious",  64'(bus.spurious),  64'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    auto_mem = 1'b1;
    set_req(0, 1'b0, 32'h600, '0);
    req_valid = '1;
    #1;
    chk("mr_first", 64'(bus.req_ready), 64'b0001);
    sb.push_back('{0, 1'b0, 32'h600 ^ KEY});
    tick();
    req_valid = '0;
    tick();
    chk("mr_rsp", 64'(bus.rsp_valid), 64'b0001);
    tick();
    auto_mem = 1'b0;

    chk("sb_empty",  64'(sb.size()), 64'd0);
    chk("rsp_count", 64'(n_rsp),     64'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
